// File: rtl/change_dispenser.sv
// change_dispenser: pays out change one coin at a time through a hopper.
// Four-state FSM with ack timeout, inter-coin gap and sticky fault flag.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 15,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] credit,
  input  logic [2:0] price,
  input  logic       hopper_ack,
  output logic       coin_req,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] remaining,
  output logic [2:0] paid
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            fault_q, fault_d;
  logic [2:0]      rem_q, rem_d;
  logic [2:0]      paid_q, paid_d;
  logic            coin_req_q, coin_req_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Next-state, counters and registered outputs decoded from next state
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    fault_d = fault_q;
    rem_d   = rem_q;
    paid_d  = paid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (credit >= price) begin
            rem_d   = credit - price;
            paid_d  = 3'd0;
            fault_d = 1'b0;
            tmo_d   = '0;
            gap_d   = '0;
            state_d = (credit == price) ? DONE : REQ;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (hopper_ack) begin
          tmo_d = '0;
          gap_d = '0;
          if (rem_q != 3'd0) rem_d = rem_q - 3'd1;
          if (paid_q != 3'd7) paid_d = paid_q + 3'd1;
          state_d = (rem_q <= 3'd1) ? DONE : GAP;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          fault_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          tmo_d   = '0;
          state_d = REQ;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    coin_req_d = (state_d == REQ);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      gap_q      <= '0;
      fault_q    <= 1'b0;
      rem_q      <= 3'd0;
      paid_q     <= 3'd0;
      coin_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      fault_q    <= fault_d;
      rem_q      <= rem_d;
      paid_q     <= paid_d;
      coin_req_q <= coin_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign coin_req  = coin_req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign remaining = rem_q;
  assign paid      = paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and random payouts checked cycle by cycle
// against a transaction-level timeline model of the dispenser.
module tb_change_dispenser;

  localparam int ACK_TIMEOUT = 15;
  localparam int GAP_CYCLES  = 2;
  localparam int MAXC        = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] credit;
  logic [2:0] price;
  logic       hopper_ack;
  logic       coin_req;
  logic       busy;
  logic       done;
  logic       fault;
  logic [2:0] remaining;
  logic [2:0] paid;

  change_dispenser #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .credit    (credit),
    .price     (price),
    .hopper_ack(hopper_ack),
    .coin_req  (coin_req),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .remaining (remaining),
    .paid      (paid)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // expected per-cycle timeline of one transaction
  bit e_req  [MAXC];
  bit e_busy [MAXC];
  bit e_done [MAXC];
  bit e_fault[MAXC];
  int e_paid [MAXC];
  int e_rem  [MAXC];
  bit a_drv  [MAXC];
  bit s_drv  [MAXC];
  int ncyc;

  // transaction knobs
  int dly[8];
  bit spur;
  bit xstart;
  int rst_at = 0;

  // model state carried between transactions
  int m_paid  = 0;
  int m_rem   = 0;
  bit m_fault = 0;

  task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc %0d: observed %0d expected %0d", tag, k, obs, exp);
    end
  endtask

  function automatic void put(int k, bit rq, bit bs, bit dn, bit ft,
                              int pd, int rm);
    e_req[k]   = rq;
    e_busy[k]  = bs;
    e_done[k]  = dn;
    e_fault[k] = ft;
    e_paid[k]  = pd;
    e_rem[k]   = rm;
  endfunction

  // Build the expected cycle timeline from credit, price and ack delays.
  function automatic void build(int cr, int pr);
    int t, pd, rm;
    bit ft;
    for (int k = 0; k < MAXC; k++) begin
      put(k, 0, 0, 0, 0, 0, 0);
      a_drv[k] = 0;
      s_drv[k] = 0;
    end
    t = 1;
    if (cr < pr) begin
      pd = m_paid;
      rm = m_rem;
      ft = 1;
    end else begin
      pd = 0;
      rm = cr - pr;
      ft = 0;
      if (rm == 0) begin
        put(t, 0, 1, 1, 0, 0, 0);
        t++;
      end
      for (int i = 0; i < cr - pr; i++) begin
        int hi;
        hi = (dly[i] < ACK_TIMEOUT) ? dly[i] + 1 : ACK_TIMEOUT;
        for (int j = 0; j < hi; j++) begin
          put(t, 1, 1, 0, 0, pd, rm);
          a_drv[t] = (j == dly[i]);
          t++;
        end
        if (dly[i] >= ACK_TIMEOUT) begin
          ft = 1;
          break;
        end
        pd++;
        rm--;
        if (rm == 0) begin
          put(t, 0, 1, 1, 0, pd, rm);
          a_drv[t] = spur && ($urandom_range(0, 1) == 1);
          t++;
        end else begin
          for (int j = 0; j < GAP_CYCLES; j++) begin
            put(t, 0, 1, 0, 0, pd, rm);
            a_drv[t] = spur && ($urandom_range(0, 1) == 1);
            t++;
          end
        end
      end
    end
    for (int k = 1; k < t; k++)
      if (xstart && $urandom_range(0, 2) == 0) s_drv[k] = 1;
    for (int k = 0; k < 2; k++) begin
      put(t, 0, 0, 0, ft, pd, rm);
      a_drv[t] = spur && ($urandom_range(0, 1) == 1);
      t++;
    end
    ncyc    = t;
    m_paid  = pd;
    m_rem   = rm;
    m_fault = ft;
    if (rst_at > 0 && rst_at < ncyc) begin
      for (int k = rst_at + 1; k < MAXC; k++) begin
        put(k, 0, 0, 0, 0, 0, 0);
        a_drv[k] = 0;
        s_drv[k] = 0;
      end
      ncyc    = rst_at + 3;
      m_paid  = 0;
      m_rem   = 0;
      m_fault = 0;
    end
  endfunction

  task automatic run_txn(int cr, int pr);
    build(cr, pr);
    @(posedge clk);
    #1;
    start      = 1'b1;
    credit     = cr[2:0];
    price      = pr[2:0];
    hopper_ack = 1'b0;
    for (int k = 1; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      check("coin_req",  k, 32'(coin_req),  32'(e_req[k]));
      check("busy",      k, 32'(busy),      32'(e_busy[k]));
      check("done",      k, 32'(done),      32'(e_done[k]));
      check("fault",     k, 32'(fault),     32'(e_fault[k]));
      check("paid",      k, 32'(paid),      32'(e_paid[k]));
      check("remaining", k, 32'(remaining), 32'(e_rem[k]));
      start      = s_drv[k];
      hopper_ack = a_drv[k];
      reset      = (k == rst_at);
      if (s_drv[k]) begin
        credit = 3'($urandom);
        price  = 3'($urandom);
      end
    end
    start      = 1'b0;
    hopper_ack = 1'b0;
    reset      = 1'b0;
    rst_at     = 0;
  endtask

  task automatic set_dly(int d);
    for (int i = 0; i < 8; i++) dly[i] = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b1;
    credit     = 3'd7;
    price      = 3'd0;
    hopper_ack = 1'b1;
    spur       = 0;
    xstart     = 0;
    set_dly(2);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_coin_req",  0, 32'(coin_req),  32'd0);
    check("rst_busy",      0, 32'(busy),      32'd0);
    check("rst_done",      0, 32'(done),      32'd0);
    check("rst_fault",     0, 32'(fault),     32'd0);
    check("rst_paid",      0, 32'(paid),      32'd0);
    check("rst_remaining", 0, 32'(remaining), 32'd0);
    reset      = 1'b0;
    start      = 1'b0;
    hopper_ack = 1'b0;

    set_dly(2);
    run_txn(5, 2);
    run_txn(3, 3);
    run_txn(1, 4);
    run_txn(0, 6);

    set_dly(2);
    dly[1] = 15;
    run_txn(7, 0);

    set_dly(1);
    rst_at = 3;
    run_txn(4, 0);
    set_dly(2);
    run_txn(2, 1);

    xstart = 1;
    spur   = 1;
    set_dly(0);
    dly[0] = 14;
    run_txn(3, 1);

    for (int n = 0; n < 30; n++) begin
      int cr, pr;
      cr     = $urandom_range(0, 7);
      pr     = $urandom_range(0, 7);
      spur   = ($urandom_range(0, 1) == 1);
      xstart = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 9))
          0:       dly[i] = 14;
          1:       dly[i] = 15;
          default: dly[i] = $urandom_range(0, 5);
        endcase
      end
      run_txn(cr, pr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
